axis_unit_adder: RTL and testbench
==================================

// Module: axis_unit_adder
// PURPOSE
//  Parametrised two-operand AXI-Stream adder for the matrix_multiplier unit_adder
//  level. It generalises the 1-bit half adder to DATA_W-bit operands, with signed
//  or unsigned mode and full-throughput joining of two independent input streams.
//  Each operand channel is buffered independently; a result is produced once both
//  operands are held; the output register is backpressure-safe.
// PARAMETERS
//  DATA_W  8   operand width in bits (>=1)
//  SIGNED  0   0: zero-extend operands; 1: sign-extend (two's complement)
//  CNT_W   16  width of the completed-result counter
// PORTS
//  clk             in   1         single clock, all logic on rising edge
//  arst_n          in   1         asynchronous active-low reset
//  s_a_tdata       in   DATA_W    operand A
//  s_a_tvalid      in   1         operand A valid
//  s_a_tready      out  1         operand A ready
//  s_b_tdata       in   DATA_W    operand B
//  s_b_tvalid      in   1         operand B valid
//  s_b_tready      out  1         operand B ready
//  m_result_tdata  out  DATA_W+1  A+B, full precision (carry/sign bit is MSB)
//  m_tvalid        out  1         result valid
//  m_tready        in   1         downstream ready
//  result_count    out  CNT_W     number of results accepted downstream
// BEHAVIOUR
//  Reset (async assert, sync release): a_full=b_full=0, a_reg=b_reg=0,
//   m_tvalid=0, m_result_tdata=0, result_count=0. s_x_tready=1 while in reset.
//  Input stage, per channel X in {a,b}: 1-deep holding reg + x_full flag.
//   s_x_tready = !x_full | join  (combinational; join defined below).
//   s_x_handshake = s_x_tvalid & s_x_tready -> x_reg<=s_x_tdata, x_full<=1.
//   Channels are independent: A may be captured many cycles before B.
//  Join: join = a_full & b_full & (!m_tvalid | m_tready).
//   On join: m_result_tdata <= ext(a_reg)+ext(b_reg), m_tvalid<=1,
//   x_full<=0 unless the same cycle has s_x_handshake (then x_full stays 1
//   and x_reg takes the new data) -> sustained 1 result/cycle.
//  ext(): DATA_W -> DATA_W+1; SIGNED=0 zero-extend, SIGNED=1 replicate MSB.
//   Result never overflows; no wrap on the sum.
//  Latency: last operand handshake at edge N -> m_tvalid=1 after edge N+1.
//  Output: m_handshake = m_tvalid & m_tready. If m_handshake & !join ->
//   m_tvalid<=0. While m_tvalid & !m_tready, m_result_tdata is held stable.
//   m_tvalid never drops without a handshake.
//  result_count increments by 1 per m_handshake; wraps 2^CNT_W-1 -> 0.
//  Backpressure: with m_tready=0 and output full, both holding regs may fill;
//   then s_a_tready=s_b_tready=0. No operand is ever dropped or duplicated.
//  Operand pairing is strictly in order: k-th A is added to k-th B.
//  Reset mid-operation: held operands and pending result are discarded;
//   no spurious m_tvalid after release.
//  No state machine beyond the a_full/b_full/m_tvalid flags; no X on outputs.
// TESTING
//  1 DATA_W=8,SIGNED=0: A=8'hFF,B=8'h01 same cycle, m_tready=1 -> 9'h100
//    one cycle later, m_tvalid 1 cycle, result_count=1.
//  2 SIGNED=1: A=8'h80(-128),B=8'hFF(-1) -> 9'h17F(-129); A=8'h7F,B=8'h01 -> 9'h080.
//  3 Skew: A=3 at cycle 0, B=4 at cycle 5 -> s_a_tready=0 cycles 1-5,
//    result 9'h007 after B's edge; A not re-captured.
//  4 Streaming 100 random pairs, both valid every cycle, m_tready=1 ->
//    100 results back-to-back, 1/cycle, in order, result_count=100.
//  5 Backpressure: m_tready=0 for 10 cycles while pairs offered -> exactly one
//    result held stable + one pair buffered, both readies low; release ->
//    results in order, none lost; random m_tready toggling vs reference model.
//  6 Assert arst_n=0 with a_full=1 and m_tvalid=1 -> all outputs reset value
//    immediately; after release, next pair gives correct sum, count restarts 0.

Source files
------------

// File: rtl/axis_unit_adder_if.sv
// Single AXI-Stream channel bundle (tdata/tvalid/tready), width set per instance.
// A transfer happens on a rising edge where tvalid and tready are both 1;
// the master holds tdata stable and never drops tvalid until that transfer.
interface axis_unit_adder_if #(
    parameter int W = 8
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_unit_adder.sv
// Two-stream AXI-Stream adder: each operand channel has a 1-deep holding register,
// and a full-precision sum is issued into a backpressure-safe output register.
module axis_unit_adder #(
    parameter int DATA_W = 8,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    axis_unit_adder_if.slave  s_a,
    axis_unit_adder_if.slave  s_b,
    axis_unit_adder_if.master m_result,
    output logic [CNT_W-1:0]  result_count
);

    logic              a_full;
    logic              b_full;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              m_valid;
    logic [DATA_W:0]   m_data;

    logic              join_fire;
    logic              a_hs;
    logic              b_hs;
    logic              m_hs;
    logic [DATA_W:0]   a_ext;
    logic [DATA_W:0]   b_ext;

    // A pair moves to the output when both operands are held and the output
    // register is empty or being drained this cycle.
    assign join_fire = a_full & b_full & (!m_valid | m_result.tready);

    // A holding register can take new data in the same cycle it is consumed,
    // which keeps sustained throughput at one result per cycle.
    assign s_a.tready = !a_full | join_fire;
    assign s_b.tready = !b_full | join_fire;

    assign a_hs = s_a.tvalid & s_a.tready;
    assign b_hs = s_b.tvalid & s_b.tready;
    assign m_hs = m_valid & m_result.tready;

    assign a_ext = {((SIGNED != 0) ? a_reg[DATA_W-1] : 1'b0), a_reg};
    assign b_ext = {((SIGNED != 0) ? b_reg[DATA_W-1] : 1'b0), b_reg};

    assign m_result.tvalid = m_valid;
    assign m_result.tdata  = m_data;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            a_full <= 1'b0;
            a_reg  <= '0;
        end else if (a_hs) begin
            a_full <= 1'b1;
            a_reg  <= s_a.tdata;
        end else if (join_fire) begin
            a_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            b_full <= 1'b0;
            b_reg  <= '0;
        end else if (b_hs) begin
            b_full <= 1'b1;
            b_reg  <= s_b.tdata;
        end else if (join_fire) begin
            b_full <= 1'b0;
        end
    end

    // Output register: data only changes on a join, so it is stable while stalled.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (join_fire) begin
            m_valid <= 1'b1;
            m_data  <= a_ext + b_ext;
        end else if (m_hs) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            result_count <= '0;
        end else if (m_hs) begin
            result_count <= result_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_axis_unit_adder.sv
// Scoreboard bench for axis_unit_adder: an unsigned and a signed instance share
// operand stimulus; each has its own pairing model and expected-result queue.
module tb_axis_unit_adder;

    localparam int DW = 8;
    localparam int CW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    axis_unit_adder_if #(.W(DW))   ua ();
    axis_unit_adder_if #(.W(DW))   ub ();
    axis_unit_adder_if #(.W(DW+1)) ur ();
    axis_unit_adder_if #(.W(DW))   sa ();
    axis_unit_adder_if #(.W(DW))   sb ();
    axis_unit_adder_if #(.W(DW+1)) sr ();
    logic [CW-1:0] cnt_u;
    logic [CW-1:0] cnt_s;

    assign sa.tdata  = ua.tdata;
    assign sa.tvalid = ua.tvalid;
    assign sb.tdata  = ub.tdata;
    assign sb.tvalid = ub.tvalid;
    assign sr.tready = ur.tready;

    axis_unit_adder #(.DATA_W(DW), .SIGNED(0), .CNT_W(CW)) u_dut (
        .clk(clk), .arst_n(arst_n), .s_a(ua), .s_b(ub), .m_result(ur), .result_count(cnt_u)
    );
    axis_unit_adder #(.DATA_W(DW), .SIGNED(1), .CNT_W(CW)) u_dut_s (
        .clk(clk), .arst_n(arst_n), .s_a(sa), .s_b(sb), .m_result(sr), .result_count(cnt_s)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] qa[$], qb[$], qsa[$], qsb[$];
    logic [DW:0]   exp_q[$], exp_s_q[$];
    int cnt_exp = 0;
    int cnt_s_exp = 0;
    int cyc = 0;
    int out_cyc_q[$];
    logic hold = 1'b0;
    logic [DW:0] hold_data = '0;
    logic [DW-1:0] pa, pb;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW:0] u_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int x, y;
        x = int'(a);
        y = int'(b);
        return (DW+1)'(x + y);
    endfunction

    function automatic logic [DW:0] s_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int x, y;
        x = a[DW-1] ? int'(a) - (1 << DW) : int'(a);
        y = b[DW-1] ? int'(b) - (1 << DW) : int'(b);
        return (DW+1)'(x + y);
    endfunction

    // Inputs change 1ns after posedge, so the negedge sees what the next edge will see.
    always @(negedge clk) begin
        cyc++;
        if (!arst_n) begin
            qa.delete(); qb.delete(); qsa.delete(); qsb.delete();
            exp_q.delete(); exp_s_q.delete();
            cnt_exp = 0;
            cnt_s_exp = 0;
            hold = 1'b0;
        end else begin
            if (hold) begin
                check_eq("hold_valid", 32'(ur.tvalid), 32'd1);
                check_eq("hold_data", 32'(ur.tdata), 32'(hold_data));
            end
            hold = ur.tvalid & !ur.tready;
            hold_data = ur.tdata;
            if (ur.tvalid & ur.tready) begin
                if (exp_q.size() == 0) check_eq("spurious_out_u", 32'(exp_q.size()), 32'd1);
                else check_eq("sum_u", 32'(ur.tdata), 32'(exp_q.pop_front()));
                out_cyc_q.push_back(cyc);
                cnt_exp = (cnt_exp + 1) % (1 << CW);
            end
            if (sr.tvalid & sr.tready) begin
                if (exp_s_q.size() == 0) check_eq("spurious_out_s", 32'(exp_s_q.size()), 32'd1);
                else check_eq("sum_s", 32'(sr.tdata), 32'(exp_s_q.pop_front()));
                cnt_s_exp = (cnt_s_exp + 1) % (1 << CW);
            end
            if (ua.tvalid & ua.tready) qa.push_back(ua.tdata);
            if (ub.tvalid & ub.tready) qb.push_back(ub.tdata);
            if (sa.tvalid & sa.tready) qsa.push_back(sa.tdata);
            if (sb.tvalid & sb.tready) qsb.push_back(sb.tdata);
            while (qa.size() > 0 && qb.size() > 0) begin
                pa = qa.pop_front();
                pb = qb.pop_front();
                exp_q.push_back(u_sum(pa, pb));
            end
            while (qsa.size() > 0 && qsb.size() > 0) begin
                pa = qsa.pop_front();
                pb = qsb.pop_front();
                exp_s_q.push_back(s_sum(pa, pb));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input int ch, input logic [DW-1:0] d);
        int t;
        logic hs;
        t = 0;
        hs = 1'b0;
        if (ch == 0) begin ua.tvalid = 1'b1; ua.tdata = d; end
        else begin ub.tvalid = 1'b1; ub.tdata = d; end
        while (!hs && t < 300) begin
            @(negedge clk);
            hs = (ch == 0) ? ua.tready : ub.tready;
            tick();
            t++;
        end
        if (!hs) check_eq("drv_timeout", 32'(t), 32'd0);
        if (ch == 0) ua.tvalid = 1'b0;
        else ub.tvalid = 1'b0;
    endtask

    task automatic drive_chan(input int ch, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) tick();
            send_one(ch, DW'($urandom_range(0, (1 << DW) - 1)));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        ur.tready = 1'b1;
        while ((exp_q.size() != 0 || ur.tvalid) && t < 500) begin
            tick();
            t++;
        end
        check_eq("drain_u", 32'(exp_q.size()), 32'd0);
        check_eq("drain_s", 32'(exp_s_q.size()), 32'd0);
        check_eq("count_u", 32'(cnt_u), 32'(cnt_exp));
        check_eq("count_s", 32'(cnt_s), 32'(cnt_s_exp));
    endtask

    task automatic random_ready_run(input int n, input int gap_a, input int gap_b);
        logic done_a, done_b;
        int t;
        done_a = 1'b0;
        done_b = 1'b0;
        fork
            begin drive_chan(0, n, gap_a); done_a = 1'b1; end
            begin drive_chan(1, n, gap_b); done_b = 1'b1; end
            begin
                t = 0;
                while (!(done_a && done_b) && t < 4000) begin
                    ur.tready = 1'($urandom_range(0, 1));
                    tick();
                    t++;
                end
            end
        join
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int idx;
        ua.tvalid = 1'b0; ua.tdata = '0;
        ub.tvalid = 1'b0; ub.tdata = '0;
        ur.tready = 1'b0;

        // Reset state
        repeat (2) tick();
        check_eq("rst_a_ready", 32'(ua.tready), 32'd1);
        check_eq("rst_b_ready", 32'(ub.tready), 32'd1);
        check_eq("rst_valid", 32'(ur.tvalid), 32'd0);
        check_eq("rst_data", 32'(ur.tdata), 32'd0);
        check_eq("rst_count", 32'(cnt_u), 32'd0);
        arst_n = 1'b1;
        tick();

        // 1: carry out, one-cycle latency, single-cycle valid
        ur.tready = 1'b1;
        fork
            send_one(0, 8'hFF);
            send_one(1, 8'h01);
        join
        check_eq("lat_valid_early", 32'(ur.tvalid), 32'd0);
        tick();
        check_eq("lat_valid", 32'(ur.tvalid), 32'd1);
        check_eq("carry_sum", 32'(ur.tdata), 32'h100);
        check_eq("signed_ff_01", 32'(sr.tdata), 32'h000);
        tick();
        check_eq("valid_drop", 32'(ur.tvalid), 32'd0);
        check_eq("count_one", 32'(cnt_u), 32'd1);

        // 2: signed extremes
        fork
            send_one(0, 8'h80);
            send_one(1, 8'hFF);
        join
        tick();
        check_eq("signed_neg", 32'(sr.tdata), 32'h17F);
        fork
            send_one(0, 8'h7F);
            send_one(1, 8'h01);
        join
        tick();
        check_eq("signed_pos", 32'(sr.tdata), 32'h080);
        check_eq("unsigned_pos", 32'(ur.tdata), 32'h080);
        drain();

        // 3: operand skew, A held while B is late
        ua.tvalid = 1'b1; ua.tdata = 8'd3;
        tick();
        ua.tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("skew_a_ready_low", 32'(ua.tready), 32'd0);
            if (i < 3) tick();
        end
        ub.tvalid = 1'b1; ub.tdata = 8'd4;
        tick();
        ub.tvalid = 1'b0;
        check_eq("skew_join_ready", 32'(ua.tready), 32'd1);
        tick();
        check_eq("skew_valid", 32'(ur.tvalid), 32'd1);
        check_eq("skew_sum", 32'(ur.tdata), 32'h007);
        drain();

        // 4: 100 back-to-back pairs
        idx = out_cyc_q.size();
        ur.tready = 1'b1;
        fork
            drive_chan(0, 100, 0);
            drive_chan(1, 100, 0);
        join
        drain();
        check_eq("stream_n", 32'(out_cyc_q.size() - idx), 32'd100);
        if (out_cyc_q.size() >= idx + 100)
            check_eq("stream_b2b", 32'(out_cyc_q[idx+99] - out_cyc_q[idx]), 32'd99);

        // 5: stall for 10 cycles, then random backpressure
        begin
            logic done_a, done_b;
            int t;
            done_a = 1'b0;
            done_b = 1'b0;
            ur.tready = 1'b0;
            fork
                begin drive_chan(0, 12, 0); done_a = 1'b1; end
                begin drive_chan(1, 12, 0); done_b = 1'b1; end
                begin
                    repeat (10) tick();
                    check_eq("bp_valid", 32'(ur.tvalid), 32'd1);
                    check_eq("bp_a_ready", 32'(ua.tready), 32'd0);
                    check_eq("bp_b_ready", 32'(ub.tready), 32'd0);
                    check_eq("bp_pending", 32'(exp_q.size()), 32'd2);
                    t = 0;
                    while (!(done_a && done_b) && t < 4000) begin
                        ur.tready = 1'($urandom_range(0, 1));
                        tick();
                        t++;
                    end
                end
            join
            drain();
        end
        random_ready_run(40, 3, 2);

        // 6: reset with a held operand and a pending result
        ur.tready = 1'b0;
        fork
            send_one(0, 8'h11);
            send_one(1, 8'h22);
        join
        send_one(0, 8'h33);
        tick();
        check_eq("pre_rst_valid", 32'(ur.tvalid), 32'd1);
        check_eq("pre_rst_a_ready", 32'(ua.tready), 32'd0);
        arst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(ur.tvalid), 32'd0);
        check_eq("mid_rst_data", 32'(ur.tdata), 32'd0);
        check_eq("mid_rst_count", 32'(cnt_u), 32'd0);
        check_eq("mid_rst_a_ready", 32'(ua.tready), 32'd1);
        tick();
        tick();
        arst_n = 1'b1;
        ur.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_rst_no_valid", 32'(ur.tvalid), 32'd0);
        end
        fork
            send_one(0, 8'h40);
            send_one(1, 8'h05);
        join
        tick();
        check_eq("post_rst_sum", 32'(ur.tdata), 32'h045);
        drain();
        check_eq("post_rst_count", 32'(cnt_u), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
